// File: rtl/c1351_pot_ext.sv
// C1351 mouse emulation: PS/2 mouse reports become SID POTX/POTY values (proportional
// mode) or held digital joystick lines (joystick mode).
module c1351_pot_ext #(
  parameter int DIV_SHIFT  = 0,
  parameter int CLAMP      = 127,
  parameter int NOISE      = 1,
  parameter int JOY_THRESH = 2,
  parameter int JOY_HOLD   = 100000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [24:0] ps2_mouse,
  input  logic        mode,
  input  logic        pot_sample,
  output logic [7:0]  pot_x,
  output logic [7:0]  pot_y,
  output logic [1:0]  button,
  output logic [4:0]  joy
);

  localparam int AW = 6 + DIV_SHIFT;
  localparam int CW = $clog2(JOY_HOLD + 1);
  localparam logic signed [9:0] THR   = 10'(JOY_THRESH);
  localparam logic signed [9:0] LIMIT = 10'(CLAMP);
  localparam logic [CW-1:0]     HOLD  = CW'(JOY_HOLD);

  logic        toggle_q;
  logic        s1_valid_q;
  logic        report;
  logic [16:0] lfsr_q;
  logic [1:0]  noise;
  logic [1:0]  button_q;
  logic        fire_q;
  logic        rbtn_q;
  logic [1:0]  pos_act;
  logic [1:0]  neg_act;
  logic [1:0][7:0] pot_all;
  logic        unused_status;

  assign unused_status = ^ps2_mouse[3:2];
  assign report = ps2_mouse[24] ^ toggle_q;
  assign noise  = (NOISE != 0) ? {lfsr_q[8], lfsr_q[0]} : 2'b00;

  // Overflow forces full-scale in the sign direction; otherwise saturate to +/-CLAMP.
  function automatic logic signed [9:0] clamp_delta(input logic sign, input logic [7:0] mag,
                                                     input logic ovf);
    logic signed [9:0] raw;
    raw = {sign, sign, mag};
    if (ovf)              return sign ? -LIMIT : LIMIT;
    else if (raw > LIMIT) return LIMIT;
    else if (raw < -LIMIT) return -LIMIT;
    else                  return raw;
  endfunction

  // The toggle register follows the input even in reset, so release never fires a report.
  always_ff @(posedge clk_sys) begin
    toggle_q <= ps2_mouse[24];
    if (reset) begin
      s1_valid_q <= 1'b0;
      lfsr_q     <= 17'h1FFFF;
      button_q   <= 2'b00;
      fire_q     <= 1'b0;
      rbtn_q     <= 1'b0;
    end else begin
      s1_valid_q <= report;
      lfsr_q     <= {lfsr_q[15:0], lfsr_q[16] ^ lfsr_q[13]};
      button_q   <= mode ? 2'b00 : ps2_mouse[1:0];
      fire_q     <= mode & ps2_mouse[0];
      rbtn_q     <= mode & ps2_mouse[1];
    end
  end

  // Axis 0 = X (right/left), axis 1 = Y (up/down; positive delta is up).
  for (genvar gi = 0; gi < 2; gi++) begin : g_axis
    logic signed [9:0] delta_q, delta_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic [CW-1:0]     pos_cnt_q, pos_cnt_d;
    logic [CW-1:0]     neg_cnt_q, neg_cnt_d;
    logic [7:0]        pot_q, pot_d;

    always_comb begin
      delta_d   = clamp_delta(ps2_mouse[4+gi], ps2_mouse[8+8*gi +: 8], ps2_mouse[6+gi]);
      acc_d     = acc_q;
      pos_cnt_d = (pos_cnt_q != '0) ? pos_cnt_q - CW'(1) : '0;
      neg_cnt_d = (neg_cnt_q != '0) ? neg_cnt_q - CW'(1) : '0;
      pot_d     = pot_q;
      if (!mode) begin
        pos_cnt_d = '0;
        neg_cnt_d = '0;
        if (s1_valid_q) acc_d = acc_q + delta_q[AW-1:0];
      end else if (s1_valid_q) begin
        if (delta_q >= THR) begin
          pos_cnt_d = HOLD;
          neg_cnt_d = '0;
        end else if (delta_q <= -THR) begin
          neg_cnt_d = HOLD;
          pos_cnt_d = '0;
        end
      end
      // Latches the pre-update accumulator when a strobe meets an update.
      if (pot_sample) pot_d = mode ? 8'hFF : ~{1'b0, acc_q[AW-1 -: 6], noise[gi]};
    end

    always_ff @(posedge clk_sys) begin
      if (reset) begin
        delta_q   <= '0;
        acc_q     <= '0;
        pos_cnt_q <= '0;
        neg_cnt_q <= '0;
        pot_q     <= 8'hFF;
      end else begin
        delta_q   <= delta_d;
        acc_q     <= acc_d;
        pos_cnt_q <= pos_cnt_d;
        neg_cnt_q <= neg_cnt_d;
        pot_q     <= pot_d;
      end
    end

    assign pos_act[gi] = (pos_cnt_q != '0);
    assign neg_act[gi] = (neg_cnt_q != '0);
    assign pot_all[gi] = pot_q;
  end

  assign pot_x  = pot_all[0];
  assign pot_y  = pot_all[1];
  assign button = button_q;
  assign joy    = {fire_q, pos_act[0], neg_act[0], neg_act[1], pos_act[1] | rbtn_q};

endmodule
